qqspi_psram_target: RTL and testbench
=====================================

Name: qqspi_psram_target

Overview:
- Synthesizable responder for the PSRAM side of the qqspi link: decodes serial/quad read and write commands from the initiator and serves them from an internal byte-addressed RAM.
- Used as an on-chip PSRAM stand-in for simulation and FPGA bring-up, wired pin-for-pin to the initiator's cen/sclk/sio lines.
- Runs in the initiator's clock domain and edge-detects sclk; no synchronizers.

Parameters:
- ADDR_BITS, 12, byte address width of the internal RAM (2^ADDR_BITS bytes); the wire address uses its low ADDR_BITS bits.
- DUMMY_CLKS, 6, sclk rising edges between address and data for 0xEB.
- CEN_NPOL, 0, 1 = cen is active-high.

Ports:
- clk  in  1  system clock; same clock as the initiator.
- resetn  in  1  asynchronous active-low reset.
- cen  in  1  chip enable, active-low when CEN_NPOL=0.
- sclk  in  1  SPI clock from the initiator.
- sio_in  in  4  sampled sio lines; bit0 = SI/MOSI, bit1 = SO/MISO.
- sio_out  out  4  driven sio values.
- sio_oe  out  4  per-line output enable.
- busy  out  1  high while selected and not in IDLE/IGNORE.
- cmd_err  out  1  one-clk pulse on an unsupported command byte.

Behaviour:
- Reset (async, resetn=0): state=IDLE, sio_oe=0000, sio_out=0000, busy=0, cmd_err=0, counters=0. RAM contents are not cleared.
- sel = cen XOR CEN_NPOL inverted (selected when active).
- sclk_d registers sclk. rise = sclk & ~sclk_d, evaluated every clk.
- All shifting happens on rise. Outputs change in the same clk the rise is detected, so they are stable one clk before the initiator's next sampling edge.
- Deselect has priority over everything. Whenever sel=0 the block goes to IDLE and sets sio_oe=0000, including a rise in the same clk. A partial byte is discarded; committed bytes remain.
- States:
  - IDLE: sel=1 goes to CMD with bit counter=0.
  - CMD: shift sio_in[0] MSB-first for 8 rises. Decode on the 8th rise:
    - 0x02: serial write, go to ADDR (serial).
    - 0x03: serial read, go to ADDR (serial).
    - 0x38: quad write, go to ADDR (quad).
    - 0xEB: quad read, go to ADDR (quad).
    - Any other value: pulse cmd_err, go to IGNORE.
  - ADDR: 24 bits MSB-first. Serial takes 24 rises on sio_in[0]; quad takes 6 rises on sio_in[3:0]. On completion latch ptr = addr[ADDR_BITS-1:0], then:
    - 0xEB: go to DUMMY.
    - 0x03: go to RDATA.
    - Writes: go to WDATA.
  - DUMMY: sio_oe=0000. Count DUMMY_CLKS rises. On the last one, go to RDATA and drive the first nibble.
  - WDATA: shift 1 bit (serial) or 4 bits (quad) per rise. After each 8 bits, write the byte to mem[ptr] and set ptr=ptr+1. Continues until deselect.
  - RDATA: load mem[ptr] on entry and after each completed byte, then ptr=ptr+1.
    - Quad: sio_oe=1111; the high nibble is driven first, and each rise advances one nibble.
    - Serial (0x03): sio_oe=0010, data on sio_out[1] MSB-first, one bit per rise.
    - The first bit/nibble is driven in the clk that the entry-causing rise is detected.
    - Continues until deselect.
  - IGNORE: sio_oe=0000. Leave only on deselect.
- ptr wraps from 2^ADDR_BITS-1 to 0; the upper address bits are ignored.
- Byte order on the wire is big-endian: the first byte is at the lowest address.
- Wire format seen by this block:
  - cmd: 8 serial bits.
  - 0x38 / 0xEB: quad address.
  - 0x02 / 0x03: serial address.
  - 0xEB: 6 dummy clocks.
- RAM: one synchronous write port plus a read port feeding the shifter. A write and a read never occur in the same transaction.
- Unused sio_out bits are 0.

Test Plan:
- Quad write/read: 0x38, addr 0x000010, data 0xDEADBEEF, then 0xEB at 0x000010 → initiator receives 0xDEADBEEF; mem[0x10..0x13] = DE, AD, BE, EF.
- Serial: 0x02 at 0x000020 writing 0x12345678, then 0x03 at 0x000020 → MISO returns 0x12345678; sio_oe=0010 only during data.
- Byte write: 0x38 at 0x000013 with a single byte 0xA5 → reading 0x000010 returns 0xDEADBEA5.
- Wrap: ADDR_BITS=12, quad write 0x11223344 at 0x000FFE → mem[0xFFE]=11, mem[0xFFF]=22, mem[0x000]=33, mem[0x001]=44.
- Unknown command 0x9F → cmd_err high exactly one clk, sio_oe stays 0000 until cen rises, then the next 0xEB works normally.
- Abort/reset:
  - Deselect after 12 quad data bits of 0x38 → only the first byte is committed.
  - resetn low mid-RDATA → sio_oe=0000 without waiting for a clk edge, busy=0.

Source files
------------

// File: rtl/qqspi_psram_target.sv
// PSRAM-side responder for the qqspi link: decodes 0x02/0x03/0x38/0xEB from the
// initiator's cen/sclk/sio lines and serves them from an internal byte RAM.
module qqspi_psram_target #(
  parameter int ADDR_BITS  = 12,
  parameter int DUMMY_CLKS = 6,
  parameter bit CEN_NPOL   = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cen,
  input  logic       sclk,
  input  logic [3:0] sio_in,
  output logic [3:0] sio_out,
  output logic [3:0] sio_oe,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  localparam int         DEPTH      = 1 << ADDR_BITS;
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CLKS - 1);

  logic [7:0] mem [DEPTH];

  state_t               state_reg, state_next;
  logic                 sclk_d_reg;
  logic [4:0]           cnt_reg, cnt_next;
  logic [22:0]          sr_reg, sr_next;
  logic                 quad_reg, quad_next;
  logic                 rd_reg, rd_next;
  logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
  logic [7:0]           byte_reg, byte_next;
  logic [3:0]           out_reg, out_next;
  logic [3:0]           oe_reg, oe_next;
  logic                 err_reg, err_next;

  logic                 sel, rise, load, we;
  logic [4:0]           step, cnt_step;
  logic [7:0]           cmd_byte, wr_byte, rd_byte;
  logic [22:0]          addr_full;
  logic [ADDR_BITS-1:0] rd_addr;

  // Wire unit (nibble or MISO bit) starting at bit position pos of byte b.
  function automatic logic [3:0] unit_out(input logic [7:0] b, input logic [4:0] pos,
                                          input logic q);
    logic [7:0] sh;
    sh = b << pos[2:0];
    unit_out = q ? sh[7:4] : {2'b00, sh[7], 1'b0};
  endfunction

  assign sel       = ~(cen ^ CEN_NPOL);
  assign rise      = sclk & ~sclk_d_reg;
  assign step      = quad_reg ? 5'd4 : 5'd1;
  assign cnt_step  = cnt_reg + step;
  assign cmd_byte  = {sr_reg[6:0], sio_in[0]};
  assign addr_full = quad_reg ? {sr_reg[18:0], sio_in} : {sr_reg[21:0], sio_in[0]};
  assign wr_byte   = quad_reg ? {byte_reg[3:0], sio_in} : {byte_reg[6:0], sio_in[0]};

  // Asynchronous read so a serial read can drive its first bit in the very clk
  // the last address bit arrives.
  assign rd_addr = (state_reg == S_ADDR) ? addr_full[ADDR_BITS-1:0] : ptr_reg;
  assign rd_byte = mem[rd_addr];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    quad_next  = quad_reg;
    rd_next    = rd_reg;
    ptr_next   = ptr_reg;
    byte_next  = byte_reg;
    out_next   = out_reg;
    oe_next    = oe_reg;
    err_next   = 1'b0;
    we         = 1'b0;
    load       = 1'b0;
    if (!sel) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      out_next   = '0;
      oe_next    = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_CMD;
          cnt_next   = '0;
        end
        S_CMD: if (rise) begin
          sr_next  = {sr_reg[21:0], sio_in[0]};
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == 5'd7) begin
            cnt_next   = '0;
            state_next = S_ADDR;
            case (cmd_byte)
              8'h02:   begin quad_next = 1'b0; rd_next = 1'b0; end
              8'h03:   begin quad_next = 1'b0; rd_next = 1'b1; end
              8'h38:   begin quad_next = 1'b1; rd_next = 1'b0; end
              8'hEB:   begin quad_next = 1'b1; rd_next = 1'b1; end
              default: begin err_next = 1'b1; state_next = S_IGNORE; end
            endcase
          end
        end
        S_ADDR: if (rise) begin
          sr_next  = addr_full;
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == (quad_reg ? 5'd5 : 5'd23)) begin
            cnt_next = '0;
            ptr_next = addr_full[ADDR_BITS-1:0];
            if (!rd_reg)      state_next = S_WDATA;
            else if (quad_reg) state_next = S_DUMMY;
            else              load       = 1'b1;
          end
        end
        S_DUMMY: if (rise) begin
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == DUMMY_LAST) load = 1'b1;
        end
        S_WDATA: if (rise) begin
          byte_next = wr_byte;
          cnt_next  = cnt_step;
          if (cnt_step == 5'd8) begin
            we       = 1'b1;
            ptr_next = ptr_reg + ADDR_BITS'(1);
            cnt_next = '0;
          end
        end
        S_RDATA: if (rise) begin
          if (cnt_reg == 5'd8) begin
            load = 1'b1;
          end else begin
            out_next = unit_out(byte_reg, cnt_reg, quad_reg);
            cnt_next = cnt_step;
          end
        end
        default: oe_next = '0;
      endcase
      // Byte fetch into the read shifter; cnt counts bits already on the wire.
      if (load) begin
        state_next = S_RDATA;
        byte_next  = rd_byte;
        out_next   = unit_out(rd_byte, 5'd0, quad_reg);
        oe_next    = quad_reg ? 4'b1111 : 4'b0010;
        ptr_next   = rd_addr + ADDR_BITS'(1);
        cnt_next   = step;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      sclk_d_reg <= 1'b0;
      cnt_reg    <= '0;
      sr_reg     <= '0;
      quad_reg   <= 1'b0;
      rd_reg     <= 1'b0;
      ptr_reg    <= '0;
      byte_reg   <= '0;
      out_reg    <= '0;
      oe_reg     <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sclk_d_reg <= sclk;
      cnt_reg    <= cnt_next;
      sr_reg     <= sr_next;
      quad_reg   <= quad_next;
      rd_reg     <= rd_next;
      ptr_reg    <= ptr_next;
      byte_reg   <= byte_next;
      out_reg    <= out_next;
      oe_reg     <= oe_next;
      err_reg    <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr_reg] <= wr_byte;
  end

  assign sio_out = out_reg;
  assign sio_oe  = oe_reg;
  assign cmd_err = err_reg;
  assign busy    = sel && (state_reg != S_IDLE) && (state_reg != S_IGNORE);

endmodule

// File: tb/tb_qqspi_psram_target.sv
// Directed bench for qqspi_psram_target: the bench plays the initiator and keeps
// a byte-array model of the PSRAM contents to predict every read stream.
module tb_qqspi_psram_target;

  localparam int AB   = 12;
  localparam int MASK = (1 << AB) - 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cen = 1'b1;
  logic       sclk = 1'b0;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out, sio_oe;
  logic       busy, cmd_err;

  qqspi_psram_target #(.ADDR_BITS(AB), .DUMMY_CLKS(6), .CEN_NPOL(1'b0)) dut (
    .clk(clk), .resetn(resetn), .cen(cen), .sclk(sclk), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_pulses = 0;
  logic [7:0] model_mem [1 << AB];
  logic       samp_req = 1'b0, data_chk = 1'b0, exp_busy = 1'b0;
  logic [3:0] exp_oe = 4'h0, exp_out = 4'h0, cap_out = 4'h0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: checks the lines the initiator is about to sample.
  always begin
    @(posedge clk);
    #1;
    if (cmd_err === 1'b1) err_pulses++;
    if (samp_req) begin
      cmp("sio_oe", 32'(sio_oe), 32'(exp_oe));
      cmp("busy", 32'(busy), 32'(exp_busy));
      if (data_chk) cmp("sio_out", 32'(sio_out), 32'(exp_out));
      cap_out = sio_out;
    end
  end

  // One sclk period: 2 clk low (data set, outputs sampled), then 2 clk high.
  task automatic cyc(input logic [3:0] d, input logic [3:0] eoe, input logic ebusy,
                     input logic dchk, input logic [3:0] eout);
    @(negedge clk); sio_in = d; sclk = 1'b0;
    @(negedge clk); samp_req = 1'b1; exp_oe = eoe; exp_busy = ebusy;
    data_chk = dchk; exp_out = eout;
    @(negedge clk); samp_req = 1'b0; data_chk = 1'b0; sclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic begin_x();
    @(negedge clk); cen = 1'b0; sclk = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_x();
    @(negedge clk); cen = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge clk);
    cmp("desel_oe", 32'(sio_oe), 32'h0);
    cmp("desel_busy", 32'(busy), 32'h0);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) cyc({3'b000, c[i]}, 4'h0, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic addr_q(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) cyc(a[4*i +: 4], 4'h0, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic addr_s(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) cyc({3'b000, a[i]}, 4'h0, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic quad_write(input logic [23:0] a, input logic [31:0] w, input int nb,
                            input int extra_nib);
    logic [7:0] b;
    begin_x();
    send_cmd(8'h38);
    addr_q(a);
    for (int i = 0; i < nb; i++) begin
      b = w[31 - 8*i -: 8];
      cyc(b[7:4], 4'h0, 1'b1, 1'b0, 4'h0);
      cyc(b[3:0], 4'h0, 1'b1, 1'b0, 4'h0);
      model_mem[(int'(a) + i) & MASK] = b;
    end
    for (int j = 0; j < extra_nib; j++) cyc(4'h7, 4'h0, 1'b1, 1'b0, 4'h0);
    end_x();
  endtask

  task automatic quad_read(input logic [23:0] a, input int nb, output logic [31:0] w);
    logic [7:0] b;
    begin_x();
    send_cmd(8'hEB);
    addr_q(a);
    repeat (6) cyc(4'h0, 4'h0, 1'b1, 1'b0, 4'h0);
    w = '0;
    for (int i = 0; i < nb; i++) begin
      b = model_mem[(int'(a) + i) & MASK];
      cyc(4'h0, 4'hF, 1'b1, 1'b1, b[7:4]);
      w = {w[27:0], cap_out};
      cyc(4'h0, 4'hF, 1'b1, 1'b1, b[3:0]);
      w = {w[27:0], cap_out};
    end
  endtask

  task automatic serial_write(input logic [23:0] a, input logic [31:0] w);
    begin_x();
    send_cmd(8'h02);
    addr_s(a);
    for (int i = 31; i >= 0; i--) cyc({3'b000, w[i]}, 4'h0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) model_mem[(int'(a) + i) & MASK] = w[31 - 8*i -: 8];
    end_x();
  endtask

  task automatic serial_read(input logic [23:0] a, input int nb, output logic [31:0] w);
    logic [7:0] b;
    begin_x();
    send_cmd(8'h03);
    addr_s(a);
    w = '0;
    for (int i = 0; i < nb; i++) begin
      b = model_mem[(int'(a) + i) & MASK];
      for (int k = 7; k >= 0; k--) begin
        cyc(4'h0, 4'b0010, 1'b1, 1'b1, {2'b00, b[k], 1'b0});
        w = {w[30:0], cap_out[1]};
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          e0;
    cen = 1'b0;
    repeat (3) @(negedge clk);
    cmp("rst_oe", 32'(sio_oe), 32'h0);
    cmp("rst_out", 32'(sio_out), 32'h0);
    cmp("rst_busy", 32'(busy), 32'h0);
    cmp("rst_cmd_err", 32'(cmd_err), 32'h0);
    @(negedge clk); cen = 1'b1; resetn = 1'b1;
    repeat (2) @(negedge clk);

    quad_write(24'h000010, 32'hDEADBEEF, 4, 0);
    quad_read(24'h000010, 4, w); end_x();
    cmp("quad_rd_10", w, 32'hDEADBEEF);

    serial_write(24'h000020, 32'h12345678);
    serial_read(24'h000020, 4, w); end_x();
    cmp("ser_rd_20", w, 32'h12345678);

    quad_write(24'h000013, 32'hA5000000, 1, 0);
    quad_read(24'h000010, 4, w); end_x();
    cmp("byte_wr_13", w, 32'hDEADBEA5);

    quad_write(24'h000FFE, 32'h11223344, 4, 0);
    quad_read(24'h001FFE, 4, w); end_x();
    cmp("wrap_rd_ffe", w, 32'h11223344);
    quad_read(24'h000000, 2, w); end_x();
    cmp("wrap_rd_000", w, 32'h00003344);

    e0 = err_pulses;
    begin_x();
    send_cmd(8'h9F);
    cmp("cmd_err_pulse", 32'(err_pulses - e0), 32'd1);
    repeat (4) cyc(4'hF, 4'h0, 1'b0, 1'b0, 4'h0);
    cmp("cmd_err_once", 32'(err_pulses - e0), 32'd1);
    end_x();
    quad_read(24'h000010, 4, w); end_x();
    cmp("after_ignore", w, 32'hDEADBEA5);

    quad_write(24'h000040, 32'hC3C30000, 2, 0);
    quad_write(24'h000040, 32'h5A000000, 1, 1);
    quad_read(24'h000040, 2, w); end_x();
    cmp("abort_partial", w, 32'h00005AC3);

    quad_read(24'h000010, 1, w);
    cmp("pre_reset_rd", w, 32'h000000DE);
    @(negedge clk); resetn = 1'b0;
    #1;
    cmp("async_rst_oe", 32'(sio_oe), 32'h0);
    cmp("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk); cen = 1'b1; sclk = 1'b0; resetn = 1'b1;
    repeat (2) @(negedge clk);
    quad_read(24'h000010, 4, w); end_x();
    cmp("mem_kept", w, 32'hDEADBEA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
